// File: rtl/julia_iter_if.sv
// Handshake and data bus between the worker control unit and the Julia iteration engine.
interface julia_iter_if #(
  parameter int WIDTH  = 16,
  parameter int ITER_W = 8
);
  logic                     calc_start;
  logic signed [WIDTH-1:0]  z0_re, z0_im, c_re, c_im;
  logic        [ITER_W-1:0] max_iter;
  logic                     calc_done, busy, escaped;
  logic        [ITER_W-1:0] iter_count;
  logic signed [WIDTH-1:0]  final_re, final_im;

  // wcu side: issues jobs, consumes results
  modport master (
    output calc_start, z0_re, z0_im, c_re, c_im, max_iter,
    input  calc_done, busy, iter_count, escaped, final_re, final_im
  );
  // engine side
  modport slave (
    input  calc_start, z0_re, z0_im, c_re, c_im, max_iter,
    output calc_done, busy, iter_count, escaped, final_re, final_im
  );
endinterface

// File: rtl/julia_iter_engine.sv
// Julia-set iteration datapath: z <= z^2 + c once per clock until escape or limit.
module julia_iter_engine #(
  parameter int WIDTH  = 16,
  parameter int FRAC   = 12,
  parameter int ITER_W = 8
) (
  input logic          clk,
  input logic          n_rst,
  julia_iter_if.slave  bus
);
  localparam int PW = 2*WIDTH;      // product width
  localparam int SW = 2*WIDTH + 2;  // update sum width

  localparam logic signed [SW-1:0] SMAX = {{(WIDTH+3){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [SW-1:0] SMIN = {{(WIDTH+3){1'b1}}, {(WIDTH-1){1'b0}}};
  // escape threshold 4.0 in the squared (2*FRAC) scale
  localparam logic [PW:0] MAG_TH = (PW+1)'(4) << (2*FRAC);

  typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;

  state_t                  state_q, state_d;
  logic signed [WIDTH-1:0] zre_q, zre_d, zim_q, zim_d;
  logic signed [WIDTH-1:0] cre_q, cre_d, cim_q, cim_d;
  logic [ITER_W-1:0]       max_q, max_d, cnt_q, cnt_d, icnt_q, icnt_d;
  logic                    done_q, done_d, busy_q, busy_d, esc_q, esc_d;
  logic signed [WIDTH-1:0] fre_q, fre_d, fim_q, fim_d;

  function automatic logic signed [WIDTH-1:0] sat(input logic signed [SW-1:0] v);
    if (v > SMAX)      sat = SMAX[WIDTH-1:0];
    else if (v < SMIN) sat = SMIN[WIDTH-1:0];
    else               sat = v[WIDTH-1:0];
  endfunction

  // Full-precision products; squares are non-negative so mag can use zero extension.
  logic signed [PW-1:0] prr, pii, pri;
  logic signed [SW-1:0] rr_x, ii_x, ri_x, cre_x, cim_x, re_diff, re_sh, im_dbl, im_sh, re_sum, im_sum;
  logic        [PW:0]   mag;

  assign prr     = zre_q * zre_q;
  assign pii     = zim_q * zim_q;
  assign pri     = zre_q * zim_q;
  assign mag     = {1'b0, prr} + {1'b0, pii};
  assign rr_x    = {{2{prr[PW-1]}}, prr};
  assign ii_x    = {{2{pii[PW-1]}}, pii};
  assign ri_x    = {{2{pri[PW-1]}}, pri};
  assign cre_x   = {{(SW-WIDTH){cre_q[WIDTH-1]}}, cre_q};
  assign cim_x   = {{(SW-WIDTH){cim_q[WIDTH-1]}}, cim_q};
  assign re_diff = rr_x - ii_x;
  assign re_sh   = re_diff >>> FRAC;
  assign im_dbl  = ri_x <<< 1;
  assign im_sh   = im_dbl >>> FRAC;
  assign re_sum  = re_sh + cre_x;
  assign im_sum  = im_sh + cim_x;

  // Next-state and result selection; escape test outranks the limit test.
  always_comb begin
    state_d = state_q;
    zre_d = zre_q; zim_d = zim_q; cre_d = cre_q; cim_d = cim_q;
    max_d = max_q; cnt_d = cnt_q; icnt_d = icnt_q;
    done_d = done_q; busy_d = busy_q; esc_d = esc_q;
    fre_d = fre_q; fim_d = fim_q;
    case (state_q)
      IDLE, DONE: begin
        if (bus.calc_start) begin
          zre_d = bus.z0_re; zim_d = bus.z0_im;
          cre_d = bus.c_re;  cim_d = bus.c_im;
          max_d = bus.max_iter; cnt_d = '0;
          done_d = 1'b0; busy_d = 1'b1;
          state_d = ITER;
        end
      end
      ITER: begin
        if (mag > MAG_TH || cnt_q == max_q) begin
          esc_d  = (mag > MAG_TH);
          fre_d  = zre_q; fim_d = zim_q;
          icnt_d = cnt_q;
          done_d = 1'b1; busy_d = 1'b0;
          state_d = DONE;
        end else begin
          zre_d = sat(re_sum);
          zim_d = sat(im_sum);
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous clear.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q <= IDLE;
      zre_q <= '0; zim_q <= '0; cre_q <= '0; cim_q <= '0;
      max_q <= '0; cnt_q <= '0; icnt_q <= '0;
      done_q <= 1'b0; busy_q <= 1'b0; esc_q <= 1'b0;
      fre_q <= '0; fim_q <= '0;
    end else begin
      state_q <= state_d;
      zre_q <= zre_d; zim_q <= zim_d; cre_q <= cre_d; cim_q <= cim_d;
      max_q <= max_d; cnt_q <= cnt_d; icnt_q <= icnt_d;
      done_q <= done_d; busy_q <= busy_d; esc_q <= esc_d;
      fre_q <= fre_d; fim_q <= fim_d;
    end
  end

  assign bus.calc_done  = done_q;
  assign bus.busy       = busy_q;
  assign bus.iter_count = icnt_q;
  assign bus.escaped    = esc_q;
  assign bus.final_re   = fre_q;
  assign bus.final_im   = fim_q;
endmodule

// File: doc/julia_iter_engine.md
Name: julia_iter_engine

Overview:
- Per-pixel Julia-set iteration datapath in Julia_Worker; the calculation stage directly downstream of the worker control unit (wcu).
- wcu pulses calc_start with a pixel's starting point z0 and constant c. The block iterates z <= z^2 + c in signed fixed point, one iteration per clock, until escape (|z|^2 > 4) or the iteration limit.
- It then raises calc_done and holds the results for wcu to hand to the memory controller.

Parameters:
- WIDTH, 16, total bits of signed fixed-point operands (two's complement).
- FRAC, 12, fractional bits (default Q4.12, range [-8.0, +8.0)).
- ITER_W, 8, width of max_iter and iter_count.

Ports:
- clk  input  1  system clock, rising edge.
- n_rst  input  1  synchronous active-low reset.
- calc_start  input  1  start request from wcu; sampled in IDLE/DONE only.
- z0_re  input  WIDTH  real part of starting z.
- z0_im  input  WIDTH  imaginary part of starting z.
- c_re  input  WIDTH  real part of Julia constant.
- c_im  input  WIDTH  imaginary part of Julia constant.
- max_iter  input  ITER_W  iteration limit, unsigned.
- calc_done  output  1  results valid; level, held in DONE.
- busy  output  1  high while iterating.
- iter_count  output  ITER_W  number of z updates performed.
- escaped  output  1  1 = escape reached, 0 = limit hit.
- final_re  output  WIDTH  z real part at termination.
- final_im  output  WIDTH  z imaginary part at termination.

Behaviour:
- Reset (n_rst=0 at a rising edge):
  - state = IDLE.
  - calc_done = 0, busy = 0, iter_count = 0, escaped = 0, final_re/final_im = 0.
  - Internal z and latched c/max_iter cleared.
  - Reset mid-iteration aborts with no calc_done.
- States: IDLE, ITER, DONE.
- IDLE or DONE, calc_start=1:
  - Latch z0 into z, latch c and max_iter, count = 0.
  - calc_done = 0, busy = 1, go to ITER.
  - Otherwise hold state; DONE keeps all result outputs stable.
- ITER, evaluated every clock in this priority:
  - 1) mag = re^2 + im^2, computed in full precision (2*WIDTH+1 bits, no truncation). If mag > (4 << 2*FRAC): escaped = 1, go to DONE.
  - 2) Else if count == max_iter: escaped = 0, go to DONE.
  - 3) Else update z and increment count.
- z update rule:
  - re' = sat((re*re - im*im) >>> FRAC + c_re).
  - im' = sat((2*re*im) >>> FRAC + c_im).
  - Products are full 2*WIDTH signed; the sum is formed at 2*WIDTH+2 bits.
  - >>> is an arithmetic shift (truncates toward -inf).
  - sat clamps to [-2^(WIDTH-1), 2^(WIDTH-1)-1].
- On entering DONE:
  - final_re/final_im = current z (the value tested, not updated).
  - iter_count = count, calc_done = 1, busy = 0.
- calc_start in ITER is ignored; no queuing.
- Latency: calc_done rises k+1 clocks after the edge that samples calc_start, where k = iter_count.
- max_iter = 0: a single check. Done after 1 clock, count 0, escaped per the |z0| test.
- Count cannot wrap, since the limit check precedes the increment; max_iter = 2^ITER_W-1 is legal.
- Boundary |z|^2 exactly 4.0 does not escape (strict >).
- Inputs are sampled only on the accepting edge; later changes have no effect.

Test Plan:
- Reset then idle: n_rst low 2 clocks → calc_done=0, busy=0, iter_count=0, escaped=0, final=0.
- z0=(0,0), c=(0,0), max_iter=16 → calc_done high 17 clocks after start, iter_count=16, escaped=0, final=(0,0); busy high exactly 17 clocks.
- z0=(0,0), c=(0x1000,0) [1.0], max_iter=50:
  - z sequence 0 → 1.0 → 2.0 → 5.0.
  - |2.0|^2=4 must not escape.
  - Result: iter_count=3, escaped=1, final_re=0x5000, calc_done 4 clocks after start.
- z0=(0x3000,0) [3.0], max_iter=0 → escape on first check: iter_count=0, escaped=1, final_re=0x3000, done after 1 clock.
- Saturation: z0=(0x2000,0), c=(0x7000,0) → re' = 4+7 = 11 saturates, final_re=0x7FFF, iter_count=1, escaped=1.
- Protocol:
  - Pulse calc_start mid-ITER → ignored; results match the original job.
  - Assert n_rst low mid-ITER → IDLE next clock, no calc_done.
  - New calc_start while in DONE → calc_done drops next clock and the new job runs.
